// File: rtl/bcd_arb.sv
// Round-robin arbiter that shares one combinational binary-to-BCD converter
// among N valid/ready requesters and holds each result in a single output slot.
`timescale 1ns/1ps

module bcd_8 (
    input  logic [7:0] bin,
    output logic [9:0] bcd
);
    // Shift-add-3 over {hundreds, tens, units, binary}; hundreds never exceeds 2.
    logic [19:0] sr;
    logic        unused_bits;

    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] >= 4'd5) sr[11:8] = sr[11:8] + 4'd3;
            if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
            if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
            sr = sr << 1;
        end
    end

    assign bcd         = {sr[17:16], sr[15:12], sr[11:8]};
    assign unused_bits = ^{sr[19:18], sr[7:0]};
endmodule

module bcd_arb #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       out_bcd,
    output logic [IDW-1:0]   out_id,
    output logic [15:0]      conv_cnt
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] ptr_next;
    logic           any;
    logic           slot_free;
    logic           acc;
    logic [7:0]     sel_data;
    logic [9:0]     conv_bcd;

    assign any       = |req_valid;
    assign slot_free = !out_valid || out_ready;
    assign acc       = slot_free && any;

    // Walk the ring from the far end toward ptr so the closest valid index wins.
    always_comb begin
        int idx;
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req_valid[idx]) grant = IDW'(idx);
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDW'(i)) sel_data = req_data[8*i +: 8];
        end
    end

    bcd_8 u_bcd (
        .bin (sel_data),
        .bcd (conv_bcd)
    );

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (acc && !rst && grant == IDW'(i)) req_ready[i] = 1'b1;
        end
    end

    assign ptr_next = (grant == IDW'(N - 1)) ? '0 : grant + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_id    <= '0;
            conv_cnt  <= '0;
            ptr       <= '0;
        end else begin
            if (acc) begin
                out_valid <= 1'b1;
                out_bcd   <= conv_bcd;
                out_id    <= grant;
                ptr       <= ptr_next;
                conv_cnt  <= conv_cnt + 16'd1;
            end else if (out_ready && out_valid) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_arb.sv
// Self-checking bench for bcd_arb: directed scenarios plus randomized traffic,
// all compared against a decimal-arithmetic reference model of the arbiter.
`timescale 1ns/1ps

module tb_bcd_arb;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [9:0]       out_bcd;
    logic [IDW-1:0]   out_id;
    logic [15:0]      conv_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit         m_valid;
    logic [9:0] m_bcd;
    int         m_id;
    int         m_cnt;
    int         m_ptr;

    logic [N-1:0] obs_rdy;
    logic         obs_out_valid;
    logic [9:0]   obs_out_bcd;

    always #5 clk = ~clk;

    bcd_arb #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_id    (out_id),
        .conv_cnt  (conv_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] ref_bcd(input int v);
        return 10'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int ref_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_bcd   = '0;
        m_id    = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    // One clock: check at negedge, advance model at posedge, return at posedge+1.
    task automatic cycle();
        int           g;
        bit           acc;
        logic [N-1:0] exp_rdy;
        logic [7:0]   din;
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_bcd", 32'(out_bcd), 32'(m_bcd));
        check_eq("out_id", 32'(out_id), 32'(m_id));
        check_eq("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
        g       = ref_grant();
        acc     = (!m_valid || out_ready) && (g >= 0);
        exp_rdy = acc ? (N'(1) << g) : '0;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        obs_rdy       = req_ready;
        obs_out_valid = out_valid;
        obs_out_bcd   = out_bcd;
        din           = acc ? req_data[8*g +: 8] : 8'd0;
        @(posedge clk);
        if (acc) begin
            m_bcd   = ref_bcd(int'(din));
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (out_ready && m_valid) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        req_valid = '1;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] conv_exp [4];
    int         conv_in  [4];
    logic [9:0] rr_exp   [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_g;
        int exp_first;
        int rdy1, rdy3, del1, del3;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        model_reset();
        conv_in  = '{255, 0, 99, 100};
        conv_exp = '{10'h255, 10'h000, 10'h099, 10'h100};
        rr_exp   = '{10'h000, 10'h037, 10'h074, 10'h111};

        // reset then idle
        do_reset();
        repeat (10) cycle();
        check_eq("idle_cnt", 32'(conv_cnt), 32'd0);
        check_eq("idle_valid", 32'(out_valid), 32'd0);

        // single requester conversions
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            req_data[8*2 +: 8] = 8'(conv_in[k]);
            cycle();
            check_eq("conv_ready", 32'(obs_rdy), 32'b0100);
            check_eq("conv_bcd", 32'(out_bcd), 32'(conv_exp[k]));
            check_eq("conv_id", 32'(out_id), 32'd2);
        end
        req_valid = '0;
        cycle();
        check_eq("conv_count", 32'(conv_cnt), 32'd4);

        // round robin, all valid
        do_reset();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(i * 37);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_eq("rr_id", 32'(out_id), 32'(k % N));
            check_eq("rr_bcd", 32'(out_bcd), 32'(rr_exp[k % N]));
        end

        // back-pressure with requesters 1 and 3
        out_ready = 1'b0;
        req_valid = 4'b1010;
        req_data[8*1 +: 8] = 8'd12;
        req_data[8*3 +: 8] = 8'd200;
        repeat (5) begin
            cycle();
            check_eq("bp_ready", 32'(obs_rdy), 32'd0);
        end
        exp_first = (m_ptr <= 1) ? 1 : 3;
        first_g = -1;
        rdy1 = 0; rdy3 = 0; del1 = 0; del3 = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_rdy[1]) begin rdy1++; if (first_g < 0) first_g = 1; end
            if (obs_rdy[3]) begin rdy3++; if (first_g < 0) first_g = 3; end
            if (obs_out_valid && obs_out_bcd == ref_bcd(12))  del1++;
            if (obs_out_valid && obs_out_bcd == ref_bcd(200)) del3++;
            for (int i = 0; i < N; i++) if (obs_rdy[i]) req_valid[i] = 1'b0;
        end
        check_eq("bp_first", 32'(first_g), 32'(exp_first));
        check_eq("bp_acc1", 32'(rdy1), 32'd1);
        check_eq("bp_acc3", 32'(rdy3), 32'd1);
        check_eq("bp_del1", 32'(del1), 32'd1);
        check_eq("bp_del3", 32'(del3), 32'd1);

        // randomized traffic with random sink stalls
        for (int k = 0; k < 3000; k++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (obs_rdy[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end

        // counter wrap
        do_reset();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        for (int k = 0; k < 65536; k++) begin
            req_data[7:0] = 8'($urandom);
            cycle();
        end
        check_eq("cnt_wrap", 32'(conv_cnt), 32'd0);
        check_eq("wrap_valid", 32'(out_valid), 32'd1);

        // asynchronous reset between clock edges
        req_valid = 4'b1001;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_cnt", 32'(conv_cnt), 32'd0);
        check_eq("arst_ready", 32'(req_ready), 32'd0);
        model_reset();
        rst = 1'b0;
        cycle();
        check_eq("arst_first", 32'(obs_rdy), 32'b0001);
        check_eq("arst_id", 32'(out_id), 32'd0);
        req_valid = '0;
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
